// File: rtl/piho_pkg.sv
// Shared definitions for the PIHO host-side collector: controller states,
// result-frame tag and the fixed header word positions.
package piho_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_SUM,
        ST_OUT
    } state_t;

    localparam logic [15:0] FRAME_TAG   = 16'hA5C0;

    localparam int          W_CYCLES    = 0;
    localparam int          W_SUM_LO    = 1;
    localparam int          W_SUM_HI    = 2;
    localparam int          W_STATUS    = 3;
    localparam int          N_HDR_WORDS = 4;

    // Status word: overflow flag, unit count and the frame tag.
    function automatic logic [31:0] status_word(input logic ovf, input logic [7:0] n_units);
        return {ovf, 7'b0, n_units, FRAME_TAG};
    endfunction

endpackage

// File: rtl/piho_ring_router.sv
// Registered neighbour routing for a ring of PIHO units: each unit's
// `before` is its left neighbour's `last`, its `after` is its right
// neighbour's `first`, with wrap-around so the ring is periodic.
module piho_ring_router #(
    parameter int N_UNITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*N_UNITS-1:0]  first_bus,
    input  logic [32*N_UNITS-1:0]  last_bus,
    output logic [32*N_UNITS-1:0]  before_bus,
    output logic [32*N_UNITS-1:0]  after_bus
);

    logic [32*N_UNITS-1:0] r_before;
    logic [32*N_UNITS-1:0] r_after;

    // One-cycle registered routing; cleared on reset, resumes the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_before <= '0;
            r_after  <= '0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                r_before[32*i +: 32] <= last_bus[32*((i + N_UNITS - 1) % N_UNITS) +: 32];
                r_after[32*i +: 32]  <= first_bus[32*((i + 1) % N_UNITS) +: 32];
            end
        end
    end

    assign before_bus = r_before;
    assign after_bus  = r_after;

endmodule

// File: rtl/piho_collector.sv
// Host-side controller for a ring of PIHO units: pulses the unit reset,
// counts run cycles until every unit has finished, reduces the units'
// x2sum results into a 64-bit accumulator and streams a result frame over
// a 32-bit valid/ready port.
// Optional build macro PIHO_COLL_PERUNIT_EN appends each unit's x2sum
// (low word then high word) to the frame.
module piho_collector
    import piho_pkg::*;
#(
    parameter int N_UNITS    = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   unit_rst,
    input  logic [32*N_UNITS-1:0]  first_bus,
    input  logic [32*N_UNITS-1:0]  last_bus,
    input  logic [64*N_UNITS-1:0]  x2sum_bus,
    input  logic [N_UNITS-1:0]     finish_bus,
    output logic [32*N_UNITS-1:0]  before_bus,
    output logic [32*N_UNITS-1:0]  after_bus,
    output logic [31:0]            m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last
);

`ifdef PIHO_COLL_PERUNIT_EN
    localparam int N_WORDS = N_HDR_WORDS + 2 * N_UNITS;
`else
    localparam int N_WORDS = N_HDR_WORDS;
`endif
    localparam int WIDX_W = $clog2(N_WORDS);
    localparam int SIDX_W = $clog2(N_UNITS);
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t              r_state;
    state_t              w_next;

    logic [RCNT_W-1:0]   r_rst_cnt;
    logic [N_UNITS-1:0]  r_fin;
    logic [31:0]         r_run;
    logic [63:0]         r_acc;
    logic                r_ovf;
    logic [SIDX_W-1:0]   r_sum_idx;
    logic [WIDX_W-1:0]   r_widx;

    logic [63:0]         w_x2sum [N_UNITS];
    logic [64:0]         w_sum;
    logic                w_fin_all;
    logic                w_rst_done;
    logic                w_sum_done;
    logic                w_last_word;
    logic [31:0]         w_word;

    piho_ring_router #(
        .N_UNITS (N_UNITS)
    ) u_router (
        .clk        (clk),
        .rst        (rst),
        .first_bus  (first_bus),
        .last_bus   (last_bus),
        .before_bus (before_bus),
        .after_bus  (after_bus)
    );

    for (genvar g = 0; g < N_UNITS; g++) begin : g_x2sum
        assign w_x2sum[g] = x2sum_bus[64*g +: 64];
    end

    // A finish seen on the current edge counts, so a stale all-finished
    // ring leaves RUN after exactly one cycle.
    assign w_fin_all   = &(r_fin | finish_bus);
    assign w_rst_done  = (r_rst_cnt == RCNT_W'(RST_CYCLES - 1));
    assign w_sum_done  = (r_sum_idx == SIDX_W'(N_UNITS - 1));
    assign w_last_word = (r_widx == WIDX_W'(N_WORDS - 1));
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_x2sum[r_sum_idx]};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples the pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned and no latch is inferred.
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)                   w_next = ST_RST;
            ST_RST:  if (w_rst_done)              w_next = ST_RUN;
            ST_RUN:  if (w_fin_all)               w_next = ST_SUM;
            ST_SUM:  if (w_sum_done)              w_next = ST_OUT;
            ST_OUT:  if (m_ready && w_last_word)  w_next = ST_IDLE;
            default:                              w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; unit_rst also follows the external reset.
    always_comb begin
        busy     = (r_state != ST_IDLE);
        unit_rst = rst || (r_state == ST_RST);
        m_valid  = (r_state == ST_OUT);
        m_last   = (r_state == ST_OUT) && w_last_word;
        m_data   = (r_state == ST_OUT) ? w_word : 32'd0;
    end

    // Run datapath: reset counter, finish latch, cycle counter, reduction, word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_cnt <= '0;
            r_fin     <= '0;
            r_run     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_sum_idx <= '0;
            r_widx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rst_cnt <= '0;
                end
                ST_RST: begin
                    r_rst_cnt <= r_rst_cnt + RCNT_W'(1);
                    r_fin     <= '0;
                    r_run     <= '0;
                    r_acc     <= '0;
                    r_ovf     <= 1'b0;
                    r_sum_idx <= '0;
                    r_widx    <= '0;
                end
                ST_RUN: begin
                    r_fin <= r_fin | finish_bus;
                    if (r_run != 32'hFFFF_FFFF) begin
                        r_run <= r_run + 32'd1;
                    end
                end
                ST_SUM: begin
                    r_acc     <= w_sum[63:0];
                    r_ovf     <= r_ovf | w_sum[64];
                    r_sum_idx <= r_sum_idx + SIDX_W'(1);
                end
                ST_OUT: begin
                    if (m_ready) begin
                        r_widx <= r_widx + WIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIHO_COLL_PERUNIT_EN
    logic [63:0]        r_snap [N_UNITS];
    logic [WIDX_W-1:0]  w_pu_off;
    logic [SIDX_W-1:0]  w_pu_unit;
    logic [31:0]        w_pu_word;

    // Per-unit snapshot taken as each unit is summed, so later unit activity cannot leak into the frame.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot array has no reset; every entry is written in SUM before OUT reads it.
        if (r_state == ST_SUM) begin
            r_snap[r_sum_idx] <= w_x2sum[r_sum_idx];
        end
    end

    assign w_pu_off  = r_widx - WIDX_W'(N_HDR_WORDS);
    assign w_pu_unit = w_pu_off[SIDX_W:1];
    assign w_pu_word = w_pu_off[0] ? r_snap[w_pu_unit][63:32] : r_snap[w_pu_unit][31:0];
`endif

    // Frame word selected by the current word index.
    always_comb begin
        w_word = 32'd0;
        case (r_widx)
            WIDX_W'(W_CYCLES): w_word = r_run;
            WIDX_W'(W_SUM_LO): w_word = r_acc[31:0];
            WIDX_W'(W_SUM_HI): w_word = r_acc[63:32];
            WIDX_W'(W_STATUS): w_word = status_word(r_ovf, 8'(N_UNITS));
            default: begin
`ifdef PIHO_COLL_PERUNIT_EN
                w_word = w_pu_word;
`else
                w_word = 32'd0;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_piho_collector.sv
// Directed bench for piho_collector (N_UNITS=4, RST_CYCLES=2): routing,
// reset behaviour, run/sum/frame contents, stall handling, abort and
// restart. Expected frame length follows PIHO_COLL_PERUNIT_EN.
module tb_piho_collector;

    localparam int N  = 4;
    localparam int RC = 2;
`ifdef PIHO_COLL_PERUNIT_EN
    localparam int NW = 4 + 2 * N;
`else
    localparam int NW = 4;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           unit_rst;
    logic [32*N-1:0] first_bus;
    logic [32*N-1:0] last_bus;
    logic [64*N-1:0] x2sum_bus;
    logic [N-1:0]   finish_bus;
    logic [32*N-1:0] before_bus;
    logic [32*N-1:0] after_bus;
    logic [31:0]    m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;

    int             n_cmp = 0;
    int             n_bad = 0;

    logic [31:0]    exp_w [12];
    logic [31:0]    got_w [12];
    logic           got_l [12];

    piho_collector #(
        .N_UNITS    (N),
        .RST_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .unit_rst   (unit_rst),
        .first_bus  (first_bus),
        .last_bus   (last_bus),
        .x2sum_bus  (x2sum_bus),
        .finish_bus (finish_bus),
        .before_bus (before_bus),
        .after_bus  (after_bus),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_x2(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d);
        x2sum_bus = {d, c, b, a};
    endtask

    // Pulse start at a negedge; returns at the negedge after RUN is entered.
    task automatic launch();
        int n = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (unit_rst && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("unit_rst_len", n, RC);
    endtask

    // Run for a number of RUN edges before finish goes high, optionally
    // pulsing an ignored start part way through.
    task automatic run_for(input int edges, input bit poke_start);
        for (int j = 0; j < edges; j++) begin
            start = (poke_start && j == edges / 2);
            @(posedge clk);
            @(negedge clk);
            if (poke_start && j == edges / 2) begin
                check("start_ignored_rst", unit_rst, 0);
                check("start_ignored_busy", busy, 1);
            end
        end
        start = 1'b0;
    endtask

    // Count edges from the current negedge until the first frame word is valid.
    task automatic wait_valid();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!m_valid && n < 400);
        check("finish_to_valid", n, N + 1);
    endtask

    task automatic collect(input bit stall_pat, input bit scramble);
        int          nw      = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        logic [31:0] held    = 32'd0;
        bit          r;
        while (nw < NW && cyc < 100) begin
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held);
            end
            r = stall_pat ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            m_ready = r;
            if (m_valid && r) begin
                got_w[nw] = m_data;
                got_l[nw] = m_last;
                nw++;
                stalled = 1'b0;
            end else if (m_valid) begin
                stalled = 1'b1;
                held    = m_data;
            end
            if (scramble && cyc == 0) begin
                x2sum_bus = '1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check("frame_len", nw, NW);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("word%0d", i), got_w[i], exp_w[i]);
            check($sformatf("last%0d", i), got_l[i], (i == NW - 1));
        end
        check("busy_done", busy, 0);
        check("valid_done", m_valid, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        m_ready    = 1'b0;
        finish_bus = '0;
        for (int i = 0; i < N; i++) begin
            first_bus[32*i +: 32] = 32'(i + 1);
            last_bus[32*i +: 32]  = 32'(16 * (i + 1));
        end
        set_x2(64'd1, 64'd2, 64'd3, 64'd4);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_unit_rst", unit_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_before", before_bus, 0);
        check("rst_after", after_bus, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_unit_rst", unit_rst, 0);
        check("idle_busy", busy, 0);

        // Ring routing
        check("before0", before_bus[31:0], 64);
        check("before1", before_bus[63:32], 16);
        check("before2", before_bus[95:64], 32);
        check("after0", after_bus[31:0], 2);
        check("after3", after_bus[127:96], 1);

        // Run A: small sums, 100 run cycles, ignored start mid-run
        exp_w = '{32'd100, 32'd10, 32'd0, 32'h0004_A5C0,
                  32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 32'd4, 32'd0};
        launch();
        run_for(99, 1'b1);
        finish_bus = '1;
        wait_valid();
        finish_bus = '0;
        collect(1'b0, 1'b0);

        // Run B: stale finish, all-ones sums overflow
        set_x2('1, '1, '1, '1);
        finish_bus = '1;
        exp_w = '{32'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h8004_A5C0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        launch();
        wait_valid();
        finish_bus = '0;
        collect(1'b0, 1'b0);

        // Run C: abort mid-RUN, restart, stalled readout, units change during OUT
        set_x2({32'd1, 32'h10}, {32'd2, 32'h20}, {32'd3, 32'h30}, {32'd4, 32'h40});
        launch();
        run_for(10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_unit_rst", unit_rst, 1);
        check("abort_valid", m_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_unit_rst", unit_rst, 0);
        exp_w = '{32'd20, 32'h0000_00A0, 32'h0000_000A, 32'h0004_A5C0,
                  32'h10, 32'd1, 32'h20, 32'd2, 32'h30, 32'd3, 32'h40, 32'd4};
        launch();
        run_for(19, 1'b0);
        finish_bus = '1;
        wait_valid();
        finish_bus = '0;
        collect(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piho_collector.md
# piho_collector

Host-side companion to the PIHO lattice units: it starts and resets a ring of `N_UNITS` PIHO units and routes their boundary sites (`first`/`last`) to neighbours as `before`/`after`, so the units form one periodic lattice. When every unit reports `finish`, it reduces their `x2sum` results. It then streams a fixed result frame out over a 32-bit valid/ready port to the readout logic (UART bridge or debug core). It sits between the top-level control/readout path and the array of units, and is the reader of the units' result interface.

## Interface
Parameters:
- `N_UNITS`, default 4: number of PIHO units in the ring; range 2..16.
- `RST_CYCLES`, default 2: length of the `unit_rst` pulse, ≥1.

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: single-cycle request to launch a run.
- `busy`, out, 1: high from an accepted `start` until the last frame word is accepted.
- `unit_rst`, out, 1: reset to all units.
- `first_bus`, in, 32·N: unit i `first` in bits [32i+31:32i].
- `last_bus`, in, 32·N: unit i `last`.
- `x2sum_bus`, in, 64·N: unit i `x2sum`.
- `finish_bus`, in, N: unit i `finish`.
- `before_bus`, out, 32·N: to unit i `before`.
- `after_bus`, out, 32·N: to unit i `after`.
- `m_data`, out, 32: frame word.
- `m_valid`, out, 1: frame word valid.
- `m_ready`, in, 1: consumer accepts the word.
- `m_last`, out, 1: marks the final frame word.

## Operation
- Ring routing, registered, every cycle in every state:
  - `before[i] <= last[(i-1) mod N]`
  - `after[i] <= first[(i+1) mod N]`
- **IDLE**
  - `busy`=0.
  - `start` → RST.
- **RST**
  - `unit_rst`=1 for exactly `RST_CYCLES` cycles.
  - Clear the finish latch, the cycle counter and the accumulator.
  - Then go to RUN.
- **RUN**
  - 32-bit `run_cycles` increments every cycle and saturates at 0xFFFFFFFF.
  - Each `finish[i]` is latched sticky.
  - When all latch bits are 1 → SUM.
- **SUM**
  - One unit per cycle, i = 0..N-1.
  - `acc(64) += x2sum[i]`. Any carry out of bit 63 sets sticky `ovf`.
  - Takes N cycles, then OUT.
- **OUT**
  - Frame words, in order:
    - W0 = `run_cycles`
    - W1 = `acc[31:0]`
    - W2 = `acc[63:32]`
    - W3 = {`ovf`, 7'b0, 8'(N_UNITS), 16'hA5C0}
    - per-unit words (see Configuration)
  - A word advances on `m_valid && m_ready`.
  - `m_last` is high with the final word.
  - After the final word is accepted → IDLE.
- `start` outside IDLE is ignored and has no effect.
- `rst` asserted in any state:
  - Returns to IDLE and drops `m_valid` the same edge.
  - Asserts `unit_rst` while `rst` is high.
  - Clears all latches.

## Timing
- Reset values:
  - `busy`=0, `unit_rst`=0 (apart from following `rst` as above), `m_valid`=0, `m_last`=0, `m_data`=0.
  - `before_bus` and `after_bus` = 0 on the reset edge; routing resumes the next cycle.
- `start` sampled at edge t: `busy`=1 and `unit_rst`=1 from t+1 through t+`RST_CYCLES`.
- Routing latency: one cycle from `first`/`last` to `after`/`before`.
- Finish to data:
  - Last `finish` bit seen high at edge f → SUM occupies f+1..f+N.
  - `m_valid`=1 with W0 at f+N+1.
- Handshake rules:
  - `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a handshake, except on `rst`.
  - With `m_ready` held high, one word per cycle.
- `busy` falls on the edge after the final handshake.
- A new `start` is accepted no earlier than that edge.
- All `finish` bits already high on entry to RUN (stale unit state): RUN still lasts ≥1 cycle, `run_cycles`=1.

## Configuration
- `PIHO_COLL_PERUNIT_EN` defined:
  - Frame appends 2·N words: unit i `x2sum[31:0]` then `x2sum[63:32]`, i ascending.
  - Frame length is 4+2N words; `m_last` is on the final per-unit word.
- Undefined:
  - Frame is W0..W3 only; `m_last` is on W3.
  - No per-unit snapshot registers are built.
- Both builds: per-unit values are snapshotted during SUM, so the frame is unaffected by later unit activity.

## Structure
- Shared package `piho_pkg`:
  - State enum (IDLE, RST, RUN, SUM, OUT).
  - Frame tag constant 16'hA5C0.
  - Word indices `W_CYCLES`, `W_SUM_LO`, `W_SUM_HI`, `W_STATUS`.
- One natural sub-module, `piho_ring_router`: purely registered neighbour routing, parameterised on N.

## Test plan
- N=4, units stubbed with fixed `first`=i+1, `last`=16·(i+1) → one cycle later `before[0]`=64, `after[3]`=1, `before[2]`=32.
- Stub `x2sum` = {1,2,3,4}, `finish` rising 100 cycles after `unit_rst` falls, `m_ready`=1 → W1=10, W2=0, W3 `ovf`=0, `m_last` on W3 (macro off), `run_cycles`≈100.
- `x2sum` all 0xFFFFFFFF_FFFFFFFF → W3 bit31=1, W1/W2 = 0xFFFFFFFF_FFFFFFFC.
- `m_ready` toggling 1-0-0-1 during OUT → no word lost or duplicated; data stable while stalled.
- `rst` asserted mid-RUN, then `start` → fresh RST pulse of `RST_CYCLES`; the run completes normally.
- `PIHO_COLL_PERUNIT_EN` defined, N=4 → 12 words; words 4..11 = 1,0,2,0,3,0,4,0; `m_last` only on word 11.
